debug_dpy_pager: RTL and testbench

DEBUG_DPY_PAGER -- requirements
Module: debug_dpy_pager

---
 rtl/dpy_pkg.sv | 16 +
 rtl/hex7seg.sv | 12 +
 rtl/debug_dpy_pager.sv | 156 +++++++++++++++
 tb/tb_debug_dpy_pager.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dpy_pkg.sv
// Shared types and constants for the debug seven-segment pager.
// Segment byte layout: bit7 = decimal point, bits6:0 = segments g..a.
package dpy_pkg;

  typedef logic [7:0] seg_t;

  // All segments and the decimal point off.
  localparam seg_t SEG_BLANK = 8'h00;

  // Hex glyphs 0..F, active high, bit order g..a.
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to seven-segment glyph lookup (no decimal point).
import dpy_pkg::*;

module hex7seg (
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  // Straight table lookup.
  assign glyph = HEX_GLYPH[nibble];

endmodule

// File: rtl/debug_dpy_pager.sv
// Debug display pager: shows one 32-bit page of page_words as hex on a
// multiplexed seven-segment display. Pages advance on a rising edge of
// next_page or periodically when auto_en is set. The shown value is a
// snapshot taken only at frame start, so a page change never tears a frame.
//
// Optional feature: define DPY_BLANK_LEADING_ZERO_EN to blank the glyphs of
// leading zero digits (digit 0 always shown, decimal points unaffected).
import dpy_pkg::*;

module debug_dpy_pager #(
  parameter int CHANNEL_CNT = 4,
  parameter int DIGIT_CNT   = 8,
  parameter int SCAN_DIV    = 100000,
  parameter int AUTO_PERIOD = 100000000,
  localparam int PW = (CHANNEL_CNT > 1) ? $clog2(CHANNEL_CNT) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNEL_CNT*32-1:0] page_words,
  input  logic                      next_page,
  input  logic                      auto_en,
  input  logic                      freeze,
  input  logic [DIGIT_CNT-1:0]      dp_mask,
  output logic [DIGIT_CNT-1:0]      digit,
  output seg_t                      segment,
  output logic [PW-1:0]             page_idx
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int AW = $clog2(AUTO_PERIOD);
  localparam int DW = (DIGIT_CNT > 1) ? $clog2(DIGIT_CNT) : 1;

  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);
  localparam logic [DW-1:0] DIG_LAST  = DW'(DIGIT_CNT - 1);
  localparam logic [PW-1:0] PAGE_LAST = PW'(CHANNEL_CNT - 1);

  logic [SW-1:0] scan_cnt;
  logic          scan_tick;
  logic          frame_start;
  logic [DW-1:0] dig_idx;
  logic [AW-1:0] auto_cnt;
  logic          auto_wrap;
  logic          manual_adv;
  logic          page_adv;
  logic          next_page_q;
  logic [31:0]   page_sel;
  logic [31:0]   snapshot;
  logic [3:0]    nibble;
  logic [6:0]    glyph;
  logic          dp_bit;
  logic          blank;

  assign scan_tick   = (scan_cnt == SCAN_LAST);
  assign frame_start = scan_tick && (dig_idx == DIG_LAST);

  // A manual edge and an auto wrap in the same cycle merge into one advance.
  assign manual_adv = next_page & ~next_page_q;
  assign auto_wrap  = auto_en && (auto_cnt == AUTO_LAST);
  assign page_adv   = manual_adv | auto_wrap;

  // Scan prescaler: the wrap cycle is the scan tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)          scan_cnt <= '0;
    else if (scan_tick) scan_cnt <= '0;
    else                scan_cnt <= scan_cnt + 1'b1;
  end

  // Active digit index, stepped once per scan tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dig_idx <= '0;
    end else if (scan_tick) begin
      dig_idx <= (dig_idx == DIG_LAST) ? '0 : dig_idx + 1'b1;
    end
  end

  // Previous next_page level for rising-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) next_page_q <= 1'b0;
    else       next_page_q <= next_page;
  end

  // Auto-advance counter: idle at 0 when disabled, restarted by any advance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                           auto_cnt <= '0;
    else if (!auto_en || page_adv)       auto_cnt <= '0;
    else                                 auto_cnt <= auto_cnt + 1'b1;
  end

  // Page index; a single-page build never moves.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      page_idx <= '0;
    end else if ((CHANNEL_CNT > 1) && page_adv) begin
      page_idx <= (page_idx == PAGE_LAST) ? '0 : page_idx + 1'b1;
    end
  end

  // Select the current page word.
  always_comb begin
    page_sel = '0;
    for (int k = 0; k < CHANNEL_CNT; k++) begin
      if (page_idx == PW'(k)) page_sel = page_words[k*32 +: 32];
    end
  end

  // Snapshot is refreshed only at frame start, and not while frozen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                        snapshot <= '0;
    else if (frame_start && !freeze)  snapshot <= page_sel;
  end

  // Pick the active digit's nibble and decimal-point enable.
  always_comb begin
    nibble = '0;
    dp_bit = 1'b0;
    for (int i = 0; i < DIGIT_CNT; i++) begin
      if (dig_idx == DW'(i)) begin
        nibble = snapshot[i*4 +: 4];
        dp_bit = dp_mask[i];
      end
    end
  end

`ifdef DPY_BLANK_LEADING_ZERO_EN
  // Blank when this digit and every digit above it are zero, except digit 0.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    for (int i = 0; i < DIGIT_CNT; i++) begin
      if ((DW'(i) >= dig_idx) && (snapshot[i*4 +: 4] != 4'h0)) upper_zero = 1'b0;
    end
    blank = (dig_idx != '0) && upper_zero;
  end
`else
  assign blank = 1'b0;
`endif

  hex7seg u_hex7seg (
    .nibble (nibble),
    .glyph  (glyph)
  );

  // Registered digit/segment drive, loaded on each scan tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digit   <= '0;
      segment <= SEG_BLANK;
    end else if (scan_tick) begin
      digit   <= DIGIT_CNT'(1) << dig_idx;
      segment <= {dp_bit, (blank ? 7'h00 : glyph)};
    end
  end

endmodule

// File: tb/tb_debug_dpy_pager.sv
// Bench for debug_dpy_pager with CHANNEL_CNT=3, DIGIT_CNT=8, SCAN_DIV=4,
// AUTO_PERIOD=64. Expected glyph vectors differ when DPY_BLANK_LEADING_ZERO_EN
// is defined.
module tb_debug_dpy_pager;

  localparam int CH = 3;
  localparam int DC = 8;
  localparam int SD = 4;
  localparam int AP = 64;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic             clock = 1'b0;
  logic             reset;
  logic [CH*32-1:0] page_words;
  logic             next_page;
  logic             auto_en;
  logic             freeze;
  logic [DC-1:0]    dp_mask;
  logic [DC-1:0]    digit;
  logic [7:0]       segment;
  logic [1:0]       page_idx;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_page = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [31:0] word;
    logic [7:0]  dp;
    logic [63:0] segs;   // expected segment byte of digit d at [8d+:8]
  } vec_t;

  vec_t vecs[6];

  debug_dpy_pager #(
    .CHANNEL_CNT (CH),
    .DIGIT_CNT   (DC),
    .SCAN_DIV    (SD),
    .AUTO_PERIOD (AP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .page_words (page_words),
    .next_page  (next_page),
    .auto_en    (auto_en),
    .freeze     (freeze),
    .dp_mask    (dp_mask),
    .digit      (digit),
    .segment    (segment),
    .page_idx   (page_idx)
  );

  // Clock and watchdog.
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Wait (bounded) for a given one-hot digit, sampling on falling edges.
  task automatic wait_digit(input logic [7:0] d);
    int cnt;
    cnt = 0;
    @(negedge clock);
    while (digit !== d && cnt < 80) begin
      @(negedge clock);
      cnt++;
    end
    if (digit !== d) check("wait_digit_timeout", digit, d);
  endtask

  // Return just after a frame-start edge that happened after this call.
  task automatic wait_frame();
    wait_digit(8'h40);
    wait_digit(8'h80);
  endtask

  // Compare digits first..7 of the scan against the expected queue.
  task automatic check_digits(input string name, input int first);
    logic [7:0] d;
    for (int k = first; k < DC; k++) begin
      d = 8'(1) << k;
      wait_digit(d);
      if (exp_q.size() == 0) check("queue_empty", 32'd0, 32'd1);
      else check(name, segment, exp_q.pop_front());
    end
  endtask

  task automatic push_word(input logic [31:0] w, input logic [7:0] dp, input int first);
    for (int k = first; k < DC; k++) exp_q.push_back({dp[k], GLYPH[w[4*k +: 4]]});
  endtask

  task automatic pulse_next(input int hold);
    next_page = 1'b1;
    @(negedge clock);
    exp_page = (exp_page + 1) % CH;
    check("page_after_edge", page_idx, exp_page);
    repeat (hold - 1) @(negedge clock);
    check("page_level_held", page_idx, exp_page);
    next_page = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h1234_ABCD, 8'h00, 64'h065B4F66777C395E};
    vecs[1] = '{32'hFFFF_FFFF, 8'h00, 64'h7171717171717171};
    vecs[3] = '{32'h9876_5EF0, 8'h55, 64'h6FFF07FD6DF971BF};
`ifdef DPY_BLANK_LEADING_ZERO_EN
    vecs[2] = '{32'h0000_00A0, 8'h80, 64'h800000000000773F};
    vecs[4] = '{32'h0000_0000, 8'h01, 64'h00000000000000BF};
    vecs[5] = '{32'h0000_0100, 8'h00, 64'h0000000000063F3F};
`else
    vecs[2] = '{32'h0000_00A0, 8'h80, 64'hBF3F3F3F3F3F773F};
    vecs[4] = '{32'h0000_0000, 8'h01, 64'h3F3F3F3F3F3F3FBF};
    vecs[5] = '{32'h0000_0100, 8'h00, 64'h3F3F3F3F3F063F3F};
`endif

    reset      = 1'b1;
    next_page  = 1'b0;
    auto_en    = 1'b0;
    freeze     = 1'b0;
    dp_mask    = '0;
    page_words = {32'h2222_2222, 32'h1111_1111, 32'h1234_ABCD};

    // Reset state.
    repeat (3) @(negedge clock);
    check("rst_digit", digit, 8'h00);
    check("rst_segment", segment, 8'h00);
    check("rst_page_idx", page_idx, 2'd0);

    // First scan tick lands on the 4th edge after release.
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("pre_tick_digit", digit, 8'h00);
    @(negedge clock);
    check("first_digit", digit, 8'h01);
    check("first_segment", segment, 8'h3F);
    for (int k = 1; k < DC; k++) begin
      repeat (SD) @(negedge clock);
      check("walk_digit", digit, 8'(1) << k);
      check("walk_segment", segment, 8'h3F);
    end

    // Table-driven glyph vectors on page 0.
    for (int v = 0; v < 6; v++) begin
      page_words[31:0] = vecs[v].word;
      dp_mask = vecs[v].dp;
      wait_frame();
      for (int k = 0; k < DC; k++) exp_q.push_back(vecs[v].segs[8*k +: 8]);
      check_digits("vec_segment", 0);
    end

    // Manual paging: change mid-frame, visible only at next frame start.
    page_words[31:0] = 32'h1234_ABCD;
    dp_mask = '0;
    wait_frame();
    for (int p = 0; p < 3; p++) begin
      logic [31:0] old_w;
      logic [31:0] new_w;
      old_w = page_words[exp_page*32 +: 32];
      wait_digit(8'h01);
      pulse_next(3);
      new_w = page_words[exp_page*32 +: 32];
      push_word(old_w, 8'h00, 1);
      check_digits("page_old_frame", 1);
      push_word(new_w, 8'h00, 0);
      check_digits("page_new_frame", 0);
    end

    // Auto rotation, then a manual edge on the wrap cycle.
    @(negedge clock);
    auto_en = 1'b1;
    repeat (AP - 1) @(posedge clock);
    @(negedge clock);
    check("auto_before_wrap", page_idx, exp_page);
    @(negedge clock);
    exp_page = (exp_page + 1) % CH;
    check("auto_wrap", page_idx, exp_page);
    repeat (AP - 1) @(posedge clock);
    @(negedge clock);
    check("auto_before_coincide", page_idx, exp_page);
    next_page = 1'b1;
    @(negedge clock);
    exp_page = (exp_page + 1) % CH;
    check("coincide_single_adv", page_idx, exp_page);
    next_page = 1'b0;
    repeat (AP - 1) @(posedge clock);
    @(negedge clock);
    check("auto_restart_hold", page_idx, exp_page);
    @(negedge clock);
    exp_page = (exp_page + 1) % CH;
    check("auto_restart_wrap", page_idx, exp_page);
    auto_en = 1'b0;
    repeat (2 * AP + 2) @(negedge clock);
    check("auto_disabled", page_idx, exp_page);

    // Freeze holds the snapshot while paging continues.
    page_words = {3{32'h1234_ABCD}};
    wait_frame();
    freeze = 1'b1;
    page_words = {3{32'hFFFF_FFFF}};
    wait_frame();
    push_word(32'h1234_ABCD, 8'h00, 0);
    check_digits("freeze_hold", 0);
    pulse_next(2);
    freeze = 1'b0;
    wait_frame();
    push_word(32'hFFFF_FFFF, 8'h00, 0);
    check_digits("unfreeze", 0);

    // Asynchronous reset mid-frame at digit index 5.
    wait_digit(8'h20);
    check("pre_reset_segment", segment, 8'h71);
    reset = 1'b1;
    #1;
    check("async_rst_digit", digit, 8'h00);
    check("async_rst_segment", segment, 8'h00);
    check("async_rst_page", page_idx, 2'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("restart_pre_tick", digit, 8'h00);
    @(negedge clock);
    check("restart_digit", digit, 8'h01);
    check("restart_segment", segment, 8'h3F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
